idma_aw_credit_arbiter: RTL and testbench

// - Shares one AXI AW port between NumReq iDMA channels. Each channel's channel-coupler AW output feeds one requester slot.
// - Round-robin arbitration. The grant is locked until the AW handshake completes.
// - Per-requester outstanding-write credits limit how many AWs each channel can have in flight.
// - Write responses (B) are attributed in order: all writes share one AXI ID, so B returns in AW order.

---
 rtl/idma_aw_arb_pkg.sv | 28 ++
 rtl/idma_aw_credit_arbiter_chk.sv | 27 ++
 rtl/idma_idx_fifo.sv | 75 +++++++
 rtl/idma_aw_credit_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_idma_aw_credit_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/idma_aw_arb_pkg.sv
// Shared definitions for the iDMA AW credit arbiter.
//   idx_width / cnt_width : width helpers (a width of at least one bit)
//   req_idx_t / credit_t  : requester index and credit count types for the
//                           default configuration (4 requesters, 4 credits each)
//   arb_state_e           : grant lock state
package idma_aw_arb_pkg;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
   endfunction

   // A counter that must be able to hold the value max_out itself.
   function automatic int unsigned cnt_width(input int unsigned max_out);
      return idx_width(max_out + 32'd1);
   endfunction

   localparam int unsigned DefNumReq       = 32'd4;
   localparam int unsigned DefMaxOutPerReq = 32'd4;

   typedef logic [idx_width(DefNumReq)-1:0]       req_idx_t;
   typedef logic [cnt_width(DefMaxOutPerReq)-1:0] credit_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/idma_aw_credit_arbiter_chk.sv
// Protocol and counter-range properties of the AW credit arbiter.
//   clk_i, rst_i   : clock, synchronous reset (properties disabled in reset)
//   locked_i       : grant is locked to a requester
//   lock_valid_i   : valid of the locked requester
//   over_inc_i     : some counter incremented while at its maximum
//   under_dec_i    : some counter decremented while at zero
module idma_aw_credit_arbiter_chk (
   input logic clk_i,
   input logic rst_i,
   input logic locked_i,
   input logic lock_valid_i,
   input logic over_inc_i,
   input logic under_dec_i
);

   // A locked requester must keep its AW valid until the handshake.
   a_lock_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
      locked_i |-> lock_valid_i);

   // Credit counters stay within 0..MaxOutPerReq.
   a_no_credit_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !over_inc_i);

   a_no_credit_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !under_dec_i);

endmodule

// File: rtl/idma_idx_fifo.sv
// In-order FIFO of requester indices, synchronous active-high reset.
//   clk_i, rst_i : clock, synchronous reset
//   push_i       : write data_i (ignored while full)
//   pop_i        : drop the head entry (ignored while empty)
//   data_i       : entry to write
//   full_o       : Depth entries stored
//   empty_o      : no entries stored
//   head_o       : oldest entry, meaningful while !empty_o
module idma_idx_fifo
   import idma_aw_arb_pkg::*;
#(
   parameter int unsigned Depth  = 32'd8,
   parameter type         elem_t = req_idx_t
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push_i,
   input  logic  pop_i,
   input  elem_t data_i,
   output logic  full_o,
   output logic  empty_o,
   output elem_t head_o
);

   localparam int unsigned PtrW = idx_width(Depth);
   localparam int unsigned OccW = idx_width(Depth + 32'd1);

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [OccW-1:0] occ_t;

   localparam ptr_t LastPtr  = ptr_t'(Depth - 32'd1);
   localparam occ_t DepthOcc = occ_t'(Depth);

   elem_t mem_r [Depth];
   ptr_t  wr_ptr_r;
   ptr_t  rd_ptr_r;
   occ_t  occ_r;
   logic  do_push_s;
   logic  do_pop_s;

   assign full_o    = (occ_r == DepthOcc);
   assign empty_o   = (occ_r == occ_t'(0));
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign head_o    = mem_r[rd_ptr_r];

   // Storage array write port; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   // Read/write pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= ptr_t'(0);
         rd_ptr_r <= ptr_t'(0);
         occ_r    <= occ_t'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= (wr_ptr_r == LastPtr) ? ptr_t'(0) : wr_ptr_r + ptr_t'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= (rd_ptr_r == LastPtr) ? ptr_t'(0) : rd_ptr_r + ptr_t'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   occ_r <= occ_r + occ_t'(1);
            2'b01:   occ_r <= occ_r - occ_t'(1);
            default: occ_r <= occ_r;
         endcase
      end
   end

endmodule

// File: rtl/idma_aw_credit_arbiter.sv
// Shares one AXI AW port between NumReq iDMA channels with round-robin
// arbitration, a grant lock held until the AW handshake, per-requester
// outstanding-write credits, and in-order attribution of B responses.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   req_aw_i/valid/ready : per-requester AW channel
//   aw_o/valid/ready   : arbitrated AW channel
//   b_valid_i/ready_i  : downstream B handshake (observed only)
//   b_req_idx_o(_valid): requester owning the oldest outstanding B
//   outstanding_o      : per-requester credits in use
//   err_unexp_b_o      : one-cycle pulse after a B with nothing outstanding
//   busy_o             : any requester valid or any write outstanding
module idma_aw_credit_arbiter
   import idma_aw_arb_pkg::*;
#(
   parameter  int unsigned NumReq        = 32'd4,
   parameter  int unsigned MaxOutPerReq  = 32'd4,
   parameter  int unsigned TotalOut      = 32'd8,
   parameter  type         axi_aw_chan_t = logic,
   localparam int unsigned IdxW          = idx_width(NumReq),
   localparam int unsigned CntW          = cnt_width(MaxOutPerReq)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  axi_aw_chan_t                   req_aw_i [NumReq],
   input  logic [NumReq-1:0]              req_valid_i,
   output logic [NumReq-1:0]              req_ready_o,
   output axi_aw_chan_t                   aw_o,
   output logic                           aw_valid_o,
   input  logic                           aw_ready_i,
   input  logic                           b_valid_i,
   input  logic                           b_ready_i,
   output logic [IdxW-1:0]                b_req_idx_o,
   output logic                           b_req_idx_valid_o,
   output logic [NumReq-1:0][CntW-1:0]    outstanding_o,
   output logic                           err_unexp_b_o,
   output logic                           busy_o
);

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [CntW-1:0] cnt_t;

   localparam idx_t LastIdx = idx_t'(NumReq - 32'd1);
   localparam cnt_t CntMax  = cnt_t'(MaxOutPerReq);

   arb_state_e        state_r, state_s;
   idx_t              rr_ptr_r, lock_idx_r;
   idx_t              winner_s, gnt_idx_s, head_s, win_hi_s, win_lo_s;
   logic              found_hi_s, found_lo_s, any_elig_s;
   logic              hs_s, b_hs_s, pop_s, full_s, empty_s, err_r;
   logic [NumReq-1:0] elig_s, inc_s, dec_s, at_max_s, at_zero_s;
   cnt_t              cnt_r [NumReq];

   assign b_hs_s = b_valid_i && b_ready_i;
   assign pop_s  = b_hs_s && !empty_s;
   assign hs_s   = aw_valid_o && aw_ready_i;
   assign aw_o   = req_aw_i[gnt_idx_s];

   // Eligibility and rotating-priority winner: the lowest eligible index at or
   // after rr_ptr wins, otherwise the lowest eligible index below it. Full is
   // the registered flag, so a same-cycle pop never lets a push through.
   always_comb begin
      elig_s     = '0;
      found_hi_s = 1'b0;
      found_lo_s = 1'b0;
      win_hi_s   = idx_t'(0);
      win_lo_s   = idx_t'(0);
      for (int k = 0; k < NumReq; k++) begin
         elig_s[k] = req_valid_i[k] && (cnt_r[k] < CntMax) && !full_s;
      end
      for (int k = NumReq - 1; k >= 0; k--) begin
         if (elig_s[k] && (idx_t'(k) >= rr_ptr_r)) begin
            found_hi_s = 1'b1;
            win_hi_s   = idx_t'(k);
         end else if (elig_s[k]) begin
            found_lo_s = 1'b1;
            win_lo_s   = idx_t'(k);
         end else begin
            found_hi_s = found_hi_s;
         end
      end
      if (found_hi_s) begin
         winner_s = win_hi_s;
      end else if (found_lo_s) begin
         winner_s = win_lo_s;
      end else begin
         winner_s = rr_ptr_r;
      end
      any_elig_s = |elig_s;
   end

   // Lock FSM next state and grant selection; aw_valid_o never looks at aw_ready_i.
   always_comb begin
      state_s    = state_r;
      gnt_idx_s  = winner_s;
      aw_valid_o = 1'b0;
      case (state_r)
         IDLE: begin
            gnt_idx_s  = winner_s;
            aw_valid_o = any_elig_s;
            if (any_elig_s && !aw_ready_i) begin
               state_s = LOCKED;
            end else begin
               state_s = IDLE;
            end
         end
         LOCKED: begin
            gnt_idx_s  = lock_idx_r;
            aw_valid_o = 1'b1;
            if (aw_ready_i) begin
               state_s = IDLE;
            end else begin
               state_s = LOCKED;
            end
         end
         default: begin
            state_s    = IDLE;
            gnt_idx_s  = winner_s;
            aw_valid_o = 1'b0;
         end
      endcase
   end

   // Per-requester ready and credit take/return strobes.
   always_comb begin
      req_ready_o = '0;
      inc_s       = '0;
      dec_s       = '0;
      at_max_s    = '0;
      at_zero_s   = '0;
      for (int k = 0; k < NumReq; k++) begin
         req_ready_o[k] = hs_s && (gnt_idx_s == idx_t'(k));
         inc_s[k]       = req_ready_o[k];
         dec_s[k]       = pop_s && (head_s == idx_t'(k));
         at_max_s[k]    = (cnt_r[k] == CntMax);
         at_zero_s[k]   = (cnt_r[k] == cnt_t'(0));
      end
   end

   // Lock state, round-robin pointer, locked index and unexpected-B flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         rr_ptr_r   <= idx_t'(0);
         lock_idx_r <= idx_t'(0);
         err_r      <= 1'b0;
      end else begin
         state_r <= state_s;
         if (hs_s) begin
            rr_ptr_r <= (gnt_idx_s == LastIdx) ? idx_t'(0) : gnt_idx_s + idx_t'(1);
         end
         if ((state_r == IDLE) && (state_s == LOCKED)) begin
            lock_idx_r <= winner_s;
         end
         err_r <= b_hs_s && empty_s;
      end
   end

   // Credit counters; a grant and a B for the same requester cancel out.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NumReq; k++) begin
         if (rst_i) begin
            cnt_r[k] <= cnt_t'(0);
         end else begin
            case ({inc_s[k], dec_s[k]})
               2'b10:   cnt_r[k] <= cnt_r[k] + cnt_t'(1);
               2'b01:   cnt_r[k] <= cnt_r[k] - cnt_t'(1);
               default: cnt_r[k] <= cnt_r[k];
            endcase
         end
      end
   end

   // Credit counts presented on the output port.
   always_comb begin
      outstanding_o = '0;
      for (int k = 0; k < NumReq; k++) begin
         outstanding_o[k] = cnt_r[k];
      end
   end

   assign b_req_idx_o       = head_s;
   assign b_req_idx_valid_o = !empty_s;
   assign err_unexp_b_o     = err_r;
   assign busy_o            = (|req_valid_i) || !empty_s;

   idma_idx_fifo #(
      .Depth  (TotalOut),
      .elem_t (idx_t)
   ) i_idx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (hs_s),
      .pop_i   (pop_s),
      .data_i  (gnt_idx_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .head_o  (head_s)
   );

   idma_aw_credit_arbiter_chk i_chk (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .locked_i     (state_r == LOCKED),
      .lock_valid_i (req_valid_i[lock_idx_r]),
      .over_inc_i   (|(inc_s & ~dec_s & at_max_s)),
      .under_dec_i  (|(dec_s & ~inc_s & at_zero_s))
   );

endmodule

// File: tb/tb_idma_aw_credit_arbiter.sv
// Directed bench for idma_aw_credit_arbiter (4 requesters, 4 credits each,
// 8-deep index FIFO, 8-bit AW payload A0+k for requester k).
module tb_idma_aw_credit_arbiter;

   typedef logic [7:0] aw_t;

   logic            clk_i = 1'b0;
   logic            rst_i;
   aw_t             req_aw_i [4];
   logic [3:0]      req_valid_i;
   logic [3:0]      req_ready_o;
   aw_t             aw_o;
   logic            aw_valid_o;
   logic            aw_ready_i;
   logic            b_valid_i;
   logic            b_ready_i;
   logic [1:0]      b_req_idx_o;
   logic            b_req_idx_valid_o;
   logic [3:0][2:0] outstanding_o;
   logic            err_unexp_b_o;
   logic            busy_o;

   int n_err = 0;
   int n_chk = 0;
   int exp_heads [7] = '{3, 0, 1, 2, 3, 0, 2};

   always #5 clk_i = ~clk_i;

   idma_aw_credit_arbiter #(
      .NumReq        (32'd4),
      .MaxOutPerReq  (32'd4),
      .TotalOut      (32'd8),
      .axi_aw_chan_t (aw_t)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .req_aw_i          (req_aw_i),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .aw_o              (aw_o),
      .aw_valid_o        (aw_valid_o),
      .aw_ready_i        (aw_ready_i),
      .b_valid_i         (b_valid_i),
      .b_ready_i         (b_ready_i),
      .b_req_idx_o       (b_req_idx_o),
      .b_req_idx_valid_o (b_req_idx_valid_o),
      .outstanding_o     (outstanding_o),
      .err_unexp_b_o     (err_unexp_b_o),
      .busy_o            (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) req_aw_i[k] = 8'hA0 + 8'(k);
      rst_i = 1'b1; req_valid_i = 4'b0000; aw_ready_i = 1'b0;
      b_valid_i = 1'b0; b_ready_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0; #1;
      chk("rst_aw_valid", 32'(aw_valid_o), 32'd0);
      chk("rst_outstanding", 32'(outstanding_o), 32'd0);
      chk("rst_bidx_valid", 32'(b_req_idx_valid_o), 32'd0);
      chk("rst_err", 32'(err_unexp_b_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);

      // Single requester 2, three back-to-back AWs, then three Bs.
      req_valid_i = 4'b0100; aw_ready_i = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         chk("t1_aw_valid", 32'(aw_valid_o), 32'd1);
         chk("t1_aw", 32'(aw_o), 32'hA2);
         chk("t1_ready", 32'(req_ready_o), 32'b0100);
         tick();
      end
      req_valid_i = 4'b0000; #1;
      chk("t1_out2", 32'(outstanding_o[2]), 32'd3);
      chk("t1_bidx_valid", 32'(b_req_idx_valid_o), 32'd1);
      b_valid_i = 1'b1; b_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t1_bhead", 32'(b_req_idx_o), 32'd2);
         tick();
      end
      b_valid_i = 1'b0; b_ready_i = 1'b0; #1;
      chk("t1_out2_drained", 32'(outstanding_o[2]), 32'd0);
      chk("t1_bidx_valid_empty", 32'(b_req_idx_valid_o), 32'd0);

      // Round robin with all valid; pointer sits at 3 after requester 2.
      req_valid_i = 4'b1111; #1;
      for (int i = 0; i < 6; i++) begin
         chk("t2_aw", 32'(aw_o), 32'hA0 + 32'((3 + i) % 4));
         chk("t2_ready", 32'(req_ready_o), 32'd1 << ((3 + i) % 4));
         tick();
      end
      req_valid_i = 4'b0000; #1;
      chk("t2_out3", 32'(outstanding_o[3]), 32'd2);
      chk("t2_out0", 32'(outstanding_o[0]), 32'd2);
      chk("t2_out1", 32'(outstanding_o[1]), 32'd1);
      b_valid_i = 1'b1; b_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("t2_bhead", 32'(b_req_idx_o), 32'((3 + i) % 4));
         tick();
      end
      b_valid_i = 1'b0; b_ready_i = 1'b0; #1;
      chk("t2_drained", 32'(outstanding_o), 32'd0);

      // Lock: requester 1 stalled, requester 0 joins; then 1 handshakes, then 2.
      req_valid_i = 4'b0010; aw_ready_i = 1'b0; #1;
      chk("t3_aw_first", 32'(aw_o), 32'hA1);
      tick();
      req_valid_i = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_lock_valid", 32'(aw_valid_o), 32'd1);
         chk("t3_lock_aw", 32'(aw_o), 32'hA1);
         chk("t3_lock_ready", 32'(req_ready_o), 32'b0000);
         tick();
      end
      aw_ready_i = 1'b1; req_valid_i = 4'b0111; #1;
      chk("t3_hs_aw", 32'(aw_o), 32'hA1);
      chk("t3_hs_ready", 32'(req_ready_o), 32'b0010);
      tick();
      chk("t3_next_aw", 32'(aw_o), 32'hA2);
      chk("t3_next_ready", 32'(req_ready_o), 32'b0100);
      tick();
      req_valid_i = 4'b0000; #1;
      chk("t3_out1", 32'(outstanding_o[1]), 32'd1);
      chk("t3_out2", 32'(outstanding_o[2]), 32'd1);
      b_valid_i = 1'b1; b_ready_i = 1'b1;
      chk("t3_bhead0", 32'(b_req_idx_o), 32'd1);
      tick();
      chk("t3_bhead1", 32'(b_req_idx_o), 32'd2);
      tick();
      b_valid_i = 1'b0; b_ready_i = 1'b0;

      // Credit limit on requester 0.
      req_valid_i = 4'b0001; #1;
      for (int i = 0; i < 4; i++) begin
         chk("t4_grant", 32'(req_ready_o), 32'b0001);
         tick();
      end
      chk("t4_exhausted", 32'(aw_valid_o), 32'd0);
      chk("t4_out0", 32'(outstanding_o[0]), 32'd4);
      b_valid_i = 1'b1; b_ready_i = 1'b1; #1;
      chk("t4_b_cycle_valid", 32'(aw_valid_o), 32'd0);
      tick();
      b_valid_i = 1'b0; b_ready_i = 1'b0; #1;
      chk("t4_one_more", 32'(aw_valid_o), 32'd1);
      tick();
      chk("t4_exhausted_again", 32'(aw_valid_o), 32'd0);
      chk("t4_out0_again", 32'(outstanding_o[0]), 32'd4);
      req_valid_i = 4'b0000; b_valid_i = 1'b1; b_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      b_valid_i = 1'b0; b_ready_i = 1'b0; #1;
      chk("t4_drained", 32'(outstanding_o), 32'd0);

      // FIFO full after 8 grants starting at requester 1.
      req_valid_i = 4'b1111; #1;
      for (int i = 0; i < 8; i++) begin
         chk("t5_aw", 32'(aw_o), 32'hA0 + 32'((1 + i) % 4));
         tick();
      end
      chk("t5_full_blocks", 32'(aw_valid_o), 32'd0);
      chk("t5_head", 32'(b_req_idx_o), 32'd1);
      b_valid_i = 1'b1; b_ready_i = 1'b1; #1;
      chk("t5_no_bypass", 32'(aw_valid_o), 32'd0);
      tick();
      req_valid_i = 4'b0100; #1;
      chk("t5_same_valid", 32'(aw_valid_o), 32'd1);
      chk("t5_same_aw", 32'(aw_o), 32'hA2);
      chk("t5_same_head", 32'(b_req_idx_o), 32'd2);
      tick();
      req_valid_i = 4'b0000; b_valid_i = 1'b0; b_ready_i = 1'b0; #1;
      chk("t5_same_cnt", 32'(outstanding_o[2]), 32'd2);
      chk("t5_out1", 32'(outstanding_o[1]), 32'd1);
      b_valid_i = 1'b1; b_ready_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         chk("t5_bhead", 32'(b_req_idx_o), 32'(exp_heads[i]));
         tick();
      end
      b_valid_i = 1'b0; b_ready_i = 1'b0; #1;
      chk("t5_drained", 32'(outstanding_o), 32'd0);

      // B with nothing outstanding.
      b_valid_i = 1'b1; b_ready_i = 1'b1; #1;
      chk("t6_err_before", 32'(err_unexp_b_o), 32'd0);
      tick();
      b_valid_i = 1'b0; b_ready_i = 1'b0;
      chk("t6_err_pulse", 32'(err_unexp_b_o), 32'd1);
      chk("t6_fifo_empty", 32'(b_req_idx_valid_o), 32'd0);
      tick();
      chk("t6_err_gone", 32'(err_unexp_b_o), 32'd0);
      chk("t6_counts", 32'(outstanding_o), 32'd0);

      // Reset while locked.
      req_valid_i = 4'b0001; aw_ready_i = 1'b1;
      tick();
      req_valid_i = 4'b0010; aw_ready_i = 1'b0; #1;
      chk("t7_pre_out0", 32'(outstanding_o[0]), 32'd1);
      tick();
      chk("t7_locked_valid", 32'(aw_valid_o), 32'd1);
      chk("t7_locked_aw", 32'(aw_o), 32'hA1);
      rst_i = 1'b1; req_valid_i = 4'b0000;
      tick();
      chk("t7_valid_dropped", 32'(aw_valid_o), 32'd0);
      chk("t7_counts_clear", 32'(outstanding_o), 32'd0);
      chk("t7_fifo_clear", 32'(b_req_idx_valid_o), 32'd0);
      rst_i = 1'b0;
      tick();
      chk("t7_idle_busy", 32'(busy_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
